// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
// Build option: BOOTH_SKIP_ZERO_EN (zero-operand bypass straight to DONE).
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } booth_state_t;

    // Booth recoding of {Q[0], Q_1}
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

    // Step counter width for an N-bit internal datapath
    function automatic int booth_cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/booth_multiplier_seq_step.sv
// One radix-2 Booth step: conditional add/sub of M into A, then an
// arithmetic right shift of {A, Q, Q_1} by one bit.
module booth_step
    import booth_pkg::*;
#(
    parameter int N = 9
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_m,
    input  logic [N-1:0] i_q,
    input  logic         i_q_1,
    output logic [N-1:0] o_a,
    output logic [N-1:0] o_q,
    output logic         o_q_1
);

    logic [N-1:0] w_sum;

    // Select add, subtract or pass-through, then shift replicating the new sign
    always_comb begin
        w_sum = i_a;
        case ({i_q[0], i_q_1})
            BOOTH_ADD: w_sum = i_a + i_m;
            BOOTH_SUB: w_sum = i_a - i_m;
            default:   w_sum = i_a;
        endcase
        o_a   = {w_sum[N-1], w_sum[N-1:1]};
        o_q   = {w_sum[0], i_q[N-1:1]};
        o_q_1 = i_q[0];
    end

endmodule

// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier with valid/ready on both sides.
// Operands are widened by one bit so the same datapath handles signed and
// unsigned products exactly. Build option: BOOTH_SKIP_ZERO_EN.
module booth_multiplier_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     mc,
    input  logic [WIDTH-1:0]     mp,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 busy
);

    localparam int N  = WIDTH + 1;
    localparam int CW = booth_cnt_w(N);
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    booth_state_t      r_state;
    logic [N-1:0]      r_a;
    logic [N-1:0]      r_m;
    logic [N-1:0]      r_q;
    logic              r_q_1;
    logic [CW-1:0]     r_count;
    logic [2*WIDTH-1:0] r_prod;
    logic              r_in_ready;
    logic              r_out_valid;
    logic              r_busy;

    logic [N-1:0]      w_mc_ext;
    logic [N-1:0]      w_mp_ext;
    logic [N-1:0]      w_a;
    logic [N-1:0]      w_q;
    logic              w_q_1;

    // Widen operands according to the requested mode
    always_comb begin
        w_mc_ext = is_signed ? {mc[WIDTH-1], mc} : {1'b0, mc};
        w_mp_ext = is_signed ? {mp[WIDTH-1], mp} : {1'b0, mp};
    end

    booth_step #(.N(N)) u_step (
        .i_a   (r_a),
        .i_m   (r_m),
        .i_q   (r_q),
        .i_q_1 (r_q_1),
        .o_a   (w_a),
        .o_q   (w_q),
        .o_q_1 (w_q_1)
    );

    // Control FSM and datapath registers with registered handshake outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_m         <= '0;
            r_q         <= '0;
            r_q_1       <= 1'b0;
            r_count     <= '0;
            r_prod      <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a        <= '0;
                        r_m        <= w_mc_ext;
                        r_q        <= w_mp_ext;
                        r_q_1      <= 1'b0;
                        r_count    <= '0;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
`ifdef BOOTH_SKIP_ZERO_EN
                        if ((mc == '0) || (mp == '0)) begin
                            r_prod      <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_state     <= CALC;
                        end
`else
                        r_state    <= CALC;
`endif
                    end
                end
                CALC: begin
                    r_a     <= w_a;
                    r_q     <= w_q;
                    r_q_1   <= w_q_1;
                    r_count <= r_count + CW'(1);
                    if (r_count == LAST_STEP) begin
                        r_prod      <= {w_a[WIDTH-2:0], w_q};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign prod      = r_prod;

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Self-checking bench for booth_multiplier_seq at WIDTH=8.
module tb_booth_multiplier_seq;

    localparam int W = 8;
    localparam int N = W + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           in_valid = 1'b0;
    logic           is_signed = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   mc = '0;
    logic [W-1:0]   mp = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [2*W-1:0] prod;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    booth_multiplier_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mc        (mc),
        .mp        (mp),
        .is_signed (is_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .prod      (prod),
        .busy      (busy)
    );

    // Reference product from plain integer arithmetic
    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic s);
        longint pa;
        longint pb;
        logic [63:0] p;
        if (s) begin
            pa = longint'($signed(a));
            pb = longint'($signed(b));
        end else begin
            pa = longint'(a);
            pb = longint'(b);
        end
        p = 64'(pa * pb);
        return p[2*W-1:0];
    endfunction

    function automatic int ref_lat(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef BOOTH_SKIP_ZERO_EN
        if (a == '0 || b == '0) return 1;
`endif
        return N;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Issue one transaction and wait (bounded) for out_valid
    task automatic do_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                          output int lat, output bit busy_ok);
        @(negedge clk);
        mc = a; mp = b; is_signed = s; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        busy_ok = (busy === 1'b1);
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (busy !== 1'b1) busy_ok = 1'b0;
        end while (out_valid !== 1'b1 && lat < 40);
    endtask

    task automatic release_out(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic txn_check(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic s);
        int lat;
        bit bok;
        check({tag, "_in_ready_pre"}, 32'(in_ready), 32'd1);
        do_txn(a, b, s, lat, bok);
        check({tag, "_latency"}, 32'(lat), 32'(ref_lat(a, b)));
        check({tag, "_prod"}, 32'(prod), 32'(ref_prod(a, b, s)));
        check({tag, "_busy"}, 32'(bok), 32'd1);
        release_out(tag);
    endtask

    initial begin
        logic [2*W-1:0] held;
        bit             hold_ok;
        int             lat;
        bit             bok;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_prod", 32'(prod), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Directed cases with hand-derived constants
        txn_check("s_m3x5", 8'hFD, 8'h05, 1'b1);
        check("s_m3x5_const", 32'(prod), 32'h0000FFF1);
        txn_check("u_ffxff", 8'hFF, 8'hFF, 1'b0);
        check("u_ffxff_const", 32'(prod), 32'h0000FE01);
        txn_check("s_ffxff", 8'hFF, 8'hFF, 1'b1);
        check("s_ffxff_const", 32'(prod), 32'h00000001);
        txn_check("s_80x80", 8'h80, 8'h80, 1'b1);
        check("s_80x80_const", 32'(prod), 32'h00004000);
        txn_check("s_7fx80", 8'h7F, 8'h80, 1'b1);
        check("s_7fx80_const", 32'(prod), 32'h0000C080);

        // Back-pressure: hold the result and ignore new operands
        do_txn(8'h5A, 8'hC3, 1'b0, lat, bok);
        check("bp_latency", 32'(lat), 32'(N));
        held = ref_prod(8'h5A, 8'hC3, 1'b0);
        hold_ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            in_valid = (i % 3 == 0);
            mc = 8'($urandom); mp = 8'($urandom); is_signed = 1'($urandom);
            @(posedge clk);
            #1;
            if (prod !== held || out_valid !== 1'b1 || in_ready !== 1'b0) hold_ok = 1'b0;
        end
        in_valid = 1'b0;
        check("bp_hold", 32'(hold_ok), 32'd1);
        release_out("bp");
        check("bp_prod_retained", 32'(prod), 32'(held));

        // Asynchronous reset in the middle of CALC
        @(negedge clk);
        mc = 8'h12; mp = 8'h34; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_prod", 32'(prod), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        txn_check("post_rst_7x6", 8'd7, 8'd6, 1'b0);
        check("post_rst_7x6_const", 32'(prod), 32'd42);

        // Zero operand
        txn_check("zero_mc", 8'h00, 8'h5A, 1'b0);
        check("zero_mc_const", 32'(prod), 32'd0);

        // Randomized transactions against the reference model
        for (int k = 0; k < 24; k++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            txn_check($sformatf("rnd%0d", k), ra, rb, rs);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
- Parametrised sequential radix-2 Booth multiplier. Next generation of the team's 4-bit Booth multiplier.
- Adds: configurable operand width, per-transaction signed/unsigned mode, a valid/ready handshake on both input and output, and a held result.
- Sits as a low-area multiply unit behind datapath controllers that tolerate multi-cycle latency.

Parameters:
- WIDTH, 8, operand width in bits (≥2). Product is 2*WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operands and mode are valid this cycle.
- in_ready  output  1  block can accept operands (high only in IDLE).
- mc  input  WIDTH  multiplicand.
- mp  input  WIDTH  multiplier.
- is_signed  input  1  1 = two's-complement operands; 0 = unsigned.
- out_valid  output  1  prod holds a completed result.
- out_ready  input  1  consumer accepts prod.
- prod  output  2*WIDTH  product.
- busy  output  1  high in CALC and DONE.

Behaviour:
- Internal width N = WIDTH+1. Operands are extended to N bits: sign-extended if is_signed=1, zero-extended otherwise. Mode is latched at acceptance.
- Registers:
  - A: N bits, accumulator.
  - M: N bits, multiplicand.
  - Q: N bits, multiplier.
  - Q_1: 1 bit.
  - count: width $clog2(N+1).
- States:
  - IDLE: in_ready=1. On in_valid, load A=0, M=ext(mc), Q=ext(mp), Q_1=0, count=0, then go to CALC.
  - CALC: one Booth step per cycle, selected by {Q[0],Q_1}:
    - 01: A=A+M.
    - 10: A=A-M.
    - 00/11: no add.
    - Then arithmetic right shift of {A,Q,Q_1} by 1; count++.
    - After the step where count reaches N-1, capture prod = lower 2*WIDTH bits of {A,Q} post-shift and go to DONE.
  - DONE: out_valid=1, prod stable. On out_ready, go to IDLE.
- Latency: out_valid rises exactly N (=WIDTH+1) rising edges after the accepting edge. Throughput is one result per N+2 cycles when out_ready is held high.
- Arithmetic:
  - Add/sub is N-bit modulo.
  - The shift replicates the post-add A[N-1].
  - The result is exact for all operand pairs in both modes, including signed -2^(WIDTH-1) squared and unsigned (2^WIDTH-1) squared.
- Handshake:
  - Inputs are ignored when in_ready=0, including during DONE.
  - Output back-pressure: DONE holds indefinitely; prod and out_valid do not change until out_ready.
  - DONE with out_ready high → IDLE next edge. A new transaction cannot be accepted on that same edge.
- Reset values (asynchronous, any time, including mid-CALC or DONE):
  - State IDLE.
  - in_ready=1, out_valid=0, busy=0, prod=0.
  - A, M, Q, Q_1, count = 0.
  - The in-flight operation is discarded; no result is emitted.
- prod retains its last value after returning to IDLE. It is only meaningful while out_valid=1.

Optional Feature:
- Macro: BOOTH_SKIP_ZERO_EN.
- Defined: on acceptance, if mc==0 or mp==0, go directly IDLE→DONE with prod=0. out_valid rises 1 edge after acceptance; CALC is skipped.
- Undefined: zero operands take the full N-cycle path. The result is still 0.

Decomposition:
- Package booth_pkg:
  - state enum {IDLE, CALC, DONE}.
  - localparam helper for count width.
  - Booth-code constants (2'b01 add, 2'b10 sub).
- Sub-module booth_step: combinational, parametrised by N. Takes A, M, Q, Q_1; returns next {A,Q,Q_1} after add/sub and arithmetic shift. Instantiated once in the CALC datapath.

Test Plan:
- WIDTH=8, signed, mc=-3 (0xFD), mp=5: prod=0xFFF1. out_valid exactly 9 edges after accept; busy high throughout.
- WIDTH=8, unsigned, mc=0xFF, mp=0xFF: prod=0xFE01. Same operands with is_signed=1: prod=0x0001.
- WIDTH=8, signed, mc=mp=0x80: prod=0x4000. Also mc=0x7F, mp=0x80: prod=0xC080.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid.
  - prod stable, in_ready=0.
  - in_valid pulses are ignored (no operand change).
  - Release out_ready: IDLE next edge.
- Reset mid-CALC (assert rst at count=4): outputs go to reset values immediately, asynchronously. After release, the next transaction 7×6 yields 42 with normal latency.
- Zero operand mc=0, mp=0x5A:
  - With BOOTH_SKIP_ZERO_EN: prod=0, out_valid 1 edge after accept.
  - Without the macro: prod=0 after 9 edges.
